// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   mdu_op_e       : MDUCtrl operation codes (6/7 are no-ops)
//   MultCyclesDef  : default busy cycles for mult/multu
//   DivCyclesDef   : default busy cycles for div/divu
//   CntW           : busy counter width (covers 1..15)
package mdu_pkg;

  typedef enum logic [2:0] {
    MduMult  = 3'd0,
    MduMultu = 3'd1,
    MduDiv   = 3'd2,
    MduDivu  = 3'd3,
    MduMthi  = 3'd4,
    MduMtlo  = 3'd5
  } mdu_op_e;

  localparam int unsigned MultCyclesDef = 5;
  localparam int unsigned DivCyclesDef  = 10;
  localparam int unsigned CntW          = 4;

endpackage

// File: rtl/mdu_if.sv
// E-stage <-> MDU signal bundle.
//   master : controller/datapath side (drives MDUEN, MDUCtrl, A, B, Flush)
//   slave  : MDU side (drives Start, Busy, HI, LO)
interface mdu_if;

  logic        MDUEN;
  logic [2:0]  MDUCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output MDUEN, MDUCtrl, A, B, Flush,
    input  Start, Busy, HI, LO
  );

  modport slave (
    input  MDUEN, MDUCtrl, A, B, Flush,
    output Start, Busy, HI, LO
  );

endinterface

// File: rtl/mdu.sv
// Multiply/divide unit owning the architectural HI/LO registers.
// The result is computed on the accept edge and parked in pending registers;
// a busy counter models the multi-cycle latency and commits HI/LO when it
// reaches zero.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, aborts any in-flight op
//   bus     : mdu_if.slave (MDUEN, MDUCtrl, A, B, Flush in; Start, Busy, HI, LO out)
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDef,
  parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
  input logic  clk,
  input logic  reset_n,
  mdu_if.slave bus
);

  localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);

  logic               acc;
  logic               busy_q;
  logic [CntW-1:0]    cnt_q;
  logic [31:0]        hi_q, lo_q;
  logic [31:0]        pend_hi_q, pend_lo_q;
  logic [31:0]        res_hi, res_lo;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        quo_s, rem_s, quo_u, rem_u;

  // MDUEN while busy is dropped; the hazard unit keeps it from happening.
  assign acc       = bus.MDUEN & ~bus.Flush & ~busy_q;
  assign bus.Start = acc & ~bus.MDUCtrl[2];
  assign bus.Busy  = busy_q;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;

  always_comb begin
    prod_s = 64'($signed(bus.A)) * 64'($signed(bus.B));
    prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    // Divide-by-zero yields all-ones quotient and the dividend as remainder.
    quo_s  = '1;
    rem_s  = bus.A;
    quo_u  = '1;
    rem_u  = bus.A;
    if (bus.B != 32'd0) begin
      quo_u = bus.A / bus.B;
      rem_u = bus.A % bus.B;
      // The one signed overflow case gets a fixed answer instead of relying on
      // the simulator/synthesis interpretation of the operator.
      if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
        quo_s = 32'h8000_0000;
        rem_s = 32'd0;
      end else begin
        quo_s = $unsigned($signed(bus.A) / $signed(bus.B));
        rem_s = $unsigned($signed(bus.A) % $signed(bus.B));
      end
    end

    res_hi = 32'd0;
    res_lo = 32'd0;
    case (bus.MDUCtrl)
      MduMult:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      MduMultu: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      MduDiv:   begin res_hi = rem_s;         res_lo = quo_s;        end
      MduDivu:  begin res_hi = rem_u;         res_lo = quo_u;        end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else if (busy_q) begin
      // Flush is ignored here: the op in flight is already committed.
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CntW'(1)) begin
        busy_q <= 1'b0;
        hi_q   <= pend_hi_q;
        lo_q   <= pend_lo_q;
      end
    end else if (acc) begin
      case (bus.MDUCtrl)
        MduMult, MduMultu: begin
          pend_hi_q <= res_hi;
          pend_lo_q <= res_lo;
          cnt_q     <= MultCnt;
          busy_q    <= 1'b1;
        end
        MduDiv, MduDivu: begin
          pend_hi_q <= res_hi;
          pend_lo_q <= res_lo;
          cnt_q     <= DivCnt;
          busy_q    <= 1'b1;
        end
        MduMthi: hi_q <= bus.A;
        MduMtlo: lo_q <= bus.A;
        default: ;
      endcase
    end
  end

endmodule
